alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_pkg.sv | 26 ++
 rtl/alu_regfile.sv | 53 +++++
 rtl/alu_sequencer.sv | 141 ++++++++++++++
 tb/tb_alu_sequencer.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU sequencer slice.
//   DATA_W / REG_CNT : default operand width and register-file depth
//   ADDR_W           : register address width (fixed at 3 bits)
//   OP_CMP           : compare opcode, updates flags without writeback
//   FLAG_*           : bit positions inside the {S,Z,AC,C} flags word
//   state_e          : sequencer FSM states
package alu_sequencer_pkg;

  localparam int unsigned DATA_W  = 8;
  localparam int unsigned REG_CNT = 8;
  localparam int unsigned ADDR_W  = 3;

  localparam logic [2:0] OP_CMP = 3'b111;

  localparam int unsigned FLAG_S  = 3;
  localparam int unsigned FLAG_Z  = 2;
  localparam int unsigned FLAG_AC = 1;
  localparam int unsigned FLAG_C  = 0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_EXEC = 2'd2
  } state_e;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the ALU sequencer.
//   clk, rst_n          : clock, synchronous active-low reset (clears all entries)
//   we_i/waddr_i/wdata_i: single write port
//   re_i                : enables both synchronous read ports
//   raddr1_i/rdata1_o   : synchronous read port 1 (registered, holds when re_i=0)
//   raddr2_i/rdata2_o   : synchronous read port 2 (registered, holds when re_i=0)
//   dbg_addr_i/dbg_data_o: combinational debug read port
module alu_regfile
  import alu_sequencer_pkg::ADDR_W;
#(
  parameter int unsigned DATA_W  = alu_sequencer_pkg::DATA_W,
  parameter int unsigned REG_CNT = alu_sequencer_pkg::REG_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] raddr1_i,
  input  logic [ADDR_W-1:0] raddr2_i,
  output logic [DATA_W-1:0] rdata1_o,
  output logic [DATA_W-1:0] rdata2_o,
  input  logic [ADDR_W-1:0] dbg_addr_i,
  output logic [DATA_W-1:0] dbg_data_o
);

  logic [DATA_W-1:0] mem_q [REG_CNT];
  logic [DATA_W-1:0] rdata1_q;
  logic [DATA_W-1:0] rdata2_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mem_q    <= '{default: '0};
      rdata1_q <= '0;
      rdata2_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[waddr_i] <= wdata_i;
      end
      // Reads sample the pre-write contents of the same edge.
      if (re_i) begin
        rdata1_q <= mem_q[raddr1_i];
        rdata2_q <= mem_q[raddr2_i];
      end
    end
  end

  assign rdata1_o   = rdata1_q;
  assign rdata2_o   = rdata2_q;
  assign dbg_data_o = mem_q[dbg_addr_i];

endmodule

// File: rtl/alu_sequencer.sv
// Three-phase instruction sequencer driving an external combinational ALU.
//   clk, rst_n                         : clock, synchronous active-low reset
//   start, instr_op/rs1/rs2/rd         : instruction request, accepted when idle
//   ld_en, ld_addr, ld_data            : register-file load port (idle only)
//   busy, done                         : status (busy in READ/EXEC, done pulse after EXEC)
//   alu_opcode, alu_op1, alu_op2       : registered operands to the external ALU
//   alu_res, alu_c, alu_ac, alu_z, alu_s: ALU result and flags
//   flags                              : registered {S,Z,AC,C} of last instruction
//   dbg_addr, dbg_data                 : combinational register-file read
module alu_sequencer #(
  parameter int unsigned DATA_W  = alu_sequencer_pkg::DATA_W,
  parameter int unsigned REG_CNT = alu_sequencer_pkg::REG_CNT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        instr_op,
  input  logic [2:0]        instr_rs1,
  input  logic [2:0]        instr_rs2,
  input  logic [2:0]        instr_rd,
  input  logic              ld_en,
  input  logic [2:0]        ld_addr,
  input  logic [DATA_W-1:0] ld_data,
  output logic              busy,
  output logic              done,
  output logic [2:0]        alu_opcode,
  output logic [DATA_W-1:0] alu_op1,
  output logic [DATA_W-1:0] alu_op2,
  input  logic [DATA_W-1:0] alu_res,
  input  logic              alu_c,
  input  logic              alu_ac,
  input  logic              alu_z,
  input  logic              alu_s,
  output logic [3:0]        flags,
  input  logic [2:0]        dbg_addr,
  output logic [DATA_W-1:0] dbg_data
);

  import alu_sequencer_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        op_q, rs1_q, rs2_q, rd_q;
  logic [3:0]        flags_q, flags_d;
  logic              done_q;

  logic              accept;
  logic              rf_re;
  logic              rf_we;
  logic              wb_en;
  logic [2:0]        rf_waddr;
  logic [DATA_W-1:0] rf_wdata;
  logic              flags_we;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: if (start) state_d = ST_READ;
      ST_READ: state_d = ST_EXEC;
      ST_EXEC: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Output / control decode
  always_comb begin
    busy     = (state_q != ST_IDLE);
    accept   = (state_q == ST_IDLE) && start;
    rf_re    = (state_q == ST_READ);
    flags_we = (state_q == ST_EXEC);
    wb_en    = (state_q == ST_EXEC) && (op_q != OP_CMP);
    // Loads and writeback never collide: loads are only honoured while idle.
    rf_we    = wb_en || ((state_q == ST_IDLE) && ld_en);
    rf_waddr = wb_en ? rd_q    : ld_addr;
    rf_wdata = wb_en ? alu_res : ld_data;
  end

  always_comb begin
    flags_d          = '0;
    flags_d[FLAG_S]  = alu_s;
    flags_d[FLAG_Z]  = alu_z;
    flags_d[FLAG_AC] = alu_ac;
    flags_d[FLAG_C]  = alu_c;
  end

  // Instruction latch, flags and completion pulse
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      if (accept) begin
        op_q  <= instr_op;
        rs1_q <= instr_rs1;
        rs2_q <= instr_rs2;
        rd_q  <= instr_rd;
      end
      if (flags_we) begin
        flags_q <= flags_d;
      end
      done_q <= (state_q == ST_EXEC);
    end
  end

  // Read ports double as the op1/op2 operand registers.
  alu_regfile #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk        (clk),
    .rst_n      (rst_n),
    .we_i       (rf_we),
    .waddr_i    (rf_waddr),
    .wdata_i    (rf_wdata),
    .re_i       (rf_re),
    .raddr1_i   (rs1_q),
    .raddr2_i   (rs2_q),
    .rdata1_o   (alu_op1),
    .rdata2_o   (alu_op2),
    .dbg_addr_i (dbg_addr),
    .dbg_data_o (dbg_data)
  );

  assign alu_opcode = op_q;
  assign flags      = flags_q;
  assign done       = done_q;

endmodule

// File: tb/tb_alu_sequencer.sv
`timescale 1ns/1ps
module tb_alu_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic [2:0] instr_op, instr_rs1, instr_rs2, instr_rd;
  logic       ld_en;
  logic [2:0] ld_addr;
  logic [7:0] ld_data;
  logic       busy, done;
  logic [2:0] alu_opcode;
  logic [7:0] alu_op1, alu_op2, alu_res;
  logic       alu_c, alu_ac, alu_z, alu_s;
  logic [3:0] flags;
  logic [2:0] dbg_addr;
  logic [7:0] dbg_data;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;
  bit chk_en = 1'b0;

  alu_sequencer #(.DATA_W(8), .REG_CNT(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start),
    .instr_op(instr_op), .instr_rs1(instr_rs1), .instr_rs2(instr_rs2), .instr_rd(instr_rd),
    .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
    .busy(busy), .done(done),
    .alu_opcode(alu_opcode), .alu_op1(alu_op1), .alu_op2(alu_op2),
    .alu_res(alu_res), .alu_c(alu_c), .alu_ac(alu_ac), .alu_z(alu_z), .alu_s(alu_s),
    .flags(flags), .dbg_addr(dbg_addr), .dbg_data(dbg_data)
  );

  always #10 clk = ~clk;

  // Stub adder ALU: returns {S,Z,AC,C,res}
  function automatic logic [11:0] stub_alu(input logic [7:0] a, input logic [7:0] b);
    logic [8:0] s;
    logic [4:0] h;
    s = {1'b0, a} + {1'b0, b};
    h = {1'b0, a[3:0]} + {1'b0, b[3:0]};
    return {s[7], (s[7:0] == 8'h00), h[4], s[8], s[7:0]};
  endfunction

  always_comb {alu_s, alu_z, alu_ac, alu_c, alu_res} = stub_alu(alu_op1, alu_op2);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // The register file cannot change while an instruction is in flight, so the
  // model resolves operands at acceptance and schedules the visible effects.
  logic [7:0] m_rf [8];
  logic [3:0] m_flags;
  logic       m_done, m_busy;
  logic [2:0] m_opc;
  logic [7:0] m_op1, m_op2;
  logic [2:0] p_op, p_rd;
  logic [7:0] p_a, p_b;
  int         age;   // edges since acceptance, 0 when no instruction is pending

  task automatic model_step();
    logic [11:0] r;
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
      m_flags = 4'h0; m_done = 1'b0; m_busy = 1'b0;
      m_opc = 3'd0; m_op1 = 8'h00; m_op2 = 8'h00; age = 0;
    end else begin
      m_done = 1'b0;
      if (age == 0) begin
        if (ld_en) m_rf[ld_addr] = ld_data;
        if (start) begin
          p_op = instr_op; p_rd = instr_rd;
          p_a = m_rf[instr_rs1]; p_b = m_rf[instr_rs2];
          m_opc = instr_op; age = 1;
        end
      end else if (age == 1) begin
        m_op1 = p_a; m_op2 = p_b; age = 2;
      end else begin
        r = stub_alu(p_a, p_b);
        m_flags = r[11:8];
        if (p_op != 3'b111) m_rf[p_rd] = r[7:0];
        m_done = 1'b1; age = 0;
      end
      m_busy = (age != 0);
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", busy, m_busy);
      chk("done", done, m_done);
      chk("flags", flags, m_flags);
      chk("alu_opcode", alu_opcode, m_opc);
      chk("alu_op1", alu_op1, m_op1);
      chk("alu_op2", alu_op2, m_op2);
      if (done) done_cnt++;
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic load(input logic [2:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a; ld_data = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  task automatic set_instr(input logic [2:0] op, input logic [2:0] s1,
                           input logic [2:0] s2, input logic [2:0] d);
    instr_op = op; instr_rs1 = s1; instr_rs2 = s2; instr_rd = d;
  endtask

  task automatic issue(input logic [2:0] op, input logic [2:0] s1,
                       input logic [2:0] s2, input logic [2:0] d);
    start = 1'b1; set_instr(op, s1, s2, d);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic rf_lit(input string nm, input logic [2:0] a, input logic [7:0] exp);
    dbg_addr = a; #1;
    chk(nm, dbg_data, exp);
  endtask

  task automatic rf_vs_model();
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0]; #1;
      chk("rf_model", dbg_data, m_rf[i]);
    end
  endtask

  int d0;

  initial begin
    rst_n = 1'b0; start = 1'b0; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
    set_instr(3'd0, 3'd0, 3'd0, 3'd0); dbg_addr = '0;
    repeat (2) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_flags", flags, 0);
    rst_n = 1'b1;

    load(3'd1, 8'hF8); load(3'd2, 8'h08); load(3'd3, 8'h77);
    load(3'd4, 8'h55); load(3'd7, 8'h33);
    rf_vs_model();

    // ADD with wrap to zero
    issue(3'd2, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    chk("t1_op1", alu_op1, 8'hF8);
    chk("t1_op2", alu_op2, 8'h08);
    chk("t1_opc", alu_opcode, 3'd2);
    @(negedge clk);
    chk("t1_done", done, 1);
    chk("t1_flags", flags, 4'b0111);
    rf_lit("t1_r3", 3'd3, 8'h00);

    // CMP with rs1==rs2, no writeback
    issue(3'd7, 3'd1, 3'd1, 3'd4);
    @(negedge clk);
    chk("t2_same_op", alu_op2, 8'hF8);
    @(negedge clk);
    chk("t2_flags", flags, 4'b1011);
    rf_lit("t2_r4", 3'd4, 8'h55);

    // Start and load while busy are ignored
    @(negedge clk);
    #1 d0 = done_cnt;
    issue(3'd1, 3'd2, 3'd2, 3'd6);
    start = 1'b1; set_instr(3'd3, 3'd1, 3'd1, 3'd7);
    ld_en = 1'b1; ld_addr = 3'd1; ld_data = 8'hAA;
    @(negedge clk);
    set_instr(3'd4, 3'd4, 3'd4, 3'd0);
    @(negedge clk);
    start = 1'b0; ld_en = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("t3_one_done", done_cnt - d0, 1);
    rf_lit("t3_r6", 3'd6, 8'h10);
    rf_lit("t3_r7", 3'd7, 8'h33);
    rf_lit("t3_r1", 3'd1, 8'hF8);

    // Same-cycle load and start, rd == rs1
    ld_en = 1'b1; ld_addr = 3'd5; ld_data = 8'h11;
    issue(3'd2, 3'd5, 3'd0, 3'd5);
    ld_en = 1'b0;
    @(negedge clk);
    chk("t4_op1", alu_op1, 8'h11);
    @(negedge clk);
    rf_lit("t4_r5", 3'd5, 8'h11);

    // Back-to-back: second start accepted in the done cycle
    issue(3'd2, 3'd4, 3'd4, 3'd6);
    @(negedge clk);
    @(negedge clk);
    chk("t5_done", done, 1);
    issue(3'd3, 3'd6, 3'd1, 3'd2);
    chk("t5_busy", busy, 1);
    repeat (2) @(negedge clk);
    chk("t5_flags", flags, 4'b1011);
    rf_lit("t5_r2", 3'd2, 8'hA2);
    rf_vs_model();

    // Reset during EXEC
    issue(3'd2, 3'd1, 3'd2, 3'd3);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    chk("t6_flags", flags, 0);
    for (int i = 0; i < 8; i++) begin
      dbg_addr = i[2:0]; #1;
      chk("t6_rf_zero", dbg_data, 8'h00);
    end
    d0 = done_cnt;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    #1 chk("t6_no_done", done_cnt - d0, 0);
    rf_vs_model();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got running want finished");
    $fatal(1);
  end

endmodule
